// File: rtl/pulse_int_pkg.sv
// Shared types and helpers for the pulse-integrator sequencer.
package pulse_int_pkg;
   localparam int PULSE_W  = 8;
   localparam int SAMPLE_W = 16;
   localparam int FRAME_W  = 32;

   typedef enum logic [1:0] {IDLE, ARM, WAIT_TRIG, CAPTURE} state_t;

   // A run is only meaningful if the output window lies inside each pulse.
   function automatic logic cfg_valid(input logic [PULSE_W-1:0]  np,
                                      input logic [SAMPLE_W-1:0] ns,
                                      input logic [SAMPLE_W-1:0] st,
                                      input logic [SAMPLE_W-1:0] en);
      return (np != '0) && (ns != '0) && (st <= en) && (en < ns);
   endfunction
endpackage

// File: rtl/pulse_int_seq_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge pulse (3-cycle latency).
module sync_rise (
   input  logic aclk,
   input  logic aresetn,
   input  logic d,
   output logic rise
);
   logic [2:0] sh;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sh   <= '0;
         rise <= 1'b0;
      end else begin
         sh   <= {sh[1:0], d};
         rise <= sh[1] & ~sh[2];
      end
   end
endmodule

// File: rtl/pulse_int_seq.sv
// Aligns the free-running ADC stream to a pulse trigger and forwards n_samples beats
// per trigger to the integrator; also owns config latching and the integrator FIFO reset.
module pulse_int_seq
   import pulse_int_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int FIFO_RST_CYCLES = 16
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       enable,
   input  logic                       trigger,
   input  logic [7:0]                 cfg_n_pulses,
   input  logic [15:0]                cfg_n_samples,
   input  logic [15:0]                cfg_start_index,
   input  logic [15:0]                cfg_end_index,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   input  logic                       m_axis_tready,
   output logic                       fifo_rst_n,
   output logic [7:0]                 n_pulses,
   output logic [15:0]                n_samples,
   output logic [15:0]                start_index,
   output logic [15:0]                end_index,
   output logic                       busy,
   output logic                       cfg_err,
   output logic                       trig_miss,
   output logic                       overrun,
   output logic [31:0]                frame_count
);
   localparam int RST_W = $clog2(FIFO_RST_CYCLES + 1);

   state_t              state, state_nxt;
   logic                en_q, en_rise, trig_rise, arm_ok, rst_done;
   logic                last_beat, frame_end, beat;
   logic [RST_W-1:0]    rst_cnt;
   logic [SAMPLE_W-1:0] sample_cnt;
   logic [PULSE_W-1:0]  pulse_cnt;

   sync_rise u_trig_sync (
      .aclk    (aclk),
      .aresetn (aresetn),
      .d       (trigger),
      .rise    (trig_rise)
   );

   assign s_axis_tready = 1'b1;
   assign en_rise   = enable & ~en_q;
   // Validate the live inputs: they are latched in the same cycle the decision is made.
   assign arm_ok    = cfg_valid(cfg_n_pulses, cfg_n_samples, cfg_start_index, cfg_end_index);
   assign rst_done  = (rst_cnt == RST_W'(FIFO_RST_CYCLES - 1));
   assign beat      = s_axis_tvalid;
   assign last_beat = (sample_cnt == n_samples - 16'd1);
   assign frame_end = (pulse_cnt == n_pulses - 8'd1);

   always_ff @(posedge aclk) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (en_rise && arm_ok) state_nxt = ARM;
         ARM:       if (rst_done) state_nxt = WAIT_TRIG;
         // Stopping is only allowed on a frame boundary; it beats a coincident trigger.
         WAIT_TRIG: if (!enable && pulse_cnt == '0) state_nxt = IDLE;
                    else if (trig_rise)             state_nxt = CAPTURE;
         CAPTURE:   if (beat && last_beat) state_nxt = WAIT_TRIG;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      fifo_rst_n = (state == WAIT_TRIG) || (state == CAPTURE);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         en_q          <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         n_pulses      <= '0;
         n_samples     <= '0;
         start_index   <= '0;
         end_index     <= '0;
         cfg_err       <= 1'b0;
         trig_miss     <= 1'b0;
         overrun       <= 1'b0;
         frame_count   <= '0;
         rst_cnt       <= '0;
         sample_cnt    <= '0;
         pulse_cnt     <= '0;
      end else begin
         en_q          <= enable;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         // No backpressure path exists upstream, so a refused beat is simply lost.
         if (m_axis_tvalid && !m_axis_tready) overrun <= 1'b1;
         case (state)
            IDLE: if (en_rise) begin
               n_pulses    <= cfg_n_pulses;
               n_samples   <= cfg_n_samples;
               start_index <= cfg_start_index;
               end_index   <= cfg_end_index;
               cfg_err     <= ~arm_ok;
               if (arm_ok) begin
                  trig_miss  <= 1'b0;
                  overrun    <= 1'b0;
                  rst_cnt    <= '0;
                  sample_cnt <= '0;
                  pulse_cnt  <= '0;
               end
            end
            ARM:       rst_cnt <= rst_cnt + RST_W'(1);
            WAIT_TRIG: if (trig_rise) sample_cnt <= '0;
            CAPTURE: begin
               if (trig_rise) trig_miss <= 1'b1;
               if (beat) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= s_axis_tdata;
                  m_axis_tlast  <= last_beat;
                  if (last_beat) begin
                     sample_cnt <= '0;
                     if (frame_end) begin
                        pulse_cnt   <= '0;
                        frame_count <= frame_count + 32'd1;
                     end else begin
                        pulse_cnt <= pulse_cnt + 8'd1;
                     end
                  end else begin
                     sample_cnt <= sample_cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pulse_int_seq.sv
// Directed bench for pulse_int_seq: happy path, bad config, missed trigger, gaps, stall, stop/reset.
module tb_pulse_int_seq;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic [7:0]  cfg_n_pulses = '0;
   logic [15:0] cfg_n_samples = '0, cfg_start_index = '0, cfg_end_index = '0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast;
   logic        m_axis_tready = 1'b1;
   logic        fifo_rst_n;
   logic [7:0]  n_pulses;
   logic [15:0] n_samples, start_index, end_index;
   logic        busy, cfg_err, trig_miss, overrun;
   logic [31:0] frame_count;

   int n_chk = 0, n_err = 0;
   int beats = 0, acc = 0, tl_n = 0, dmis = 0;
   int tl_pos [0:255];
   logic        gap = 1'b0, vmode = 1'b1;
   logic        pv = 1'b0;
   logic [31:0] pd = '0;

   pulse_int_seq #(.AXIS_DATA_WIDTH(32), .FIFO_RST_CYCLES(16)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .trigger(trigger),
      .cfg_n_pulses(cfg_n_pulses), .cfg_n_samples(cfg_n_samples),
      .cfg_start_index(cfg_start_index), .cfg_end_index(cfg_end_index),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .fifo_rst_n(fifo_rst_n),
      .n_pulses(n_pulses), .n_samples(n_samples), .start_index(start_index), .end_index(end_index),
      .busy(busy), .cfg_err(cfg_err), .trig_miss(trig_miss), .overrun(overrun),
      .frame_count(frame_count)
   );

   always #5 aclk = ~aclk;

   // ADC source: incrementing data, continuous or alternating valid.
   always @(posedge aclk) begin
      #1;
      s_axis_tdata  = s_axis_tdata + 32'd1;
      s_axis_tvalid = gap ? ~s_axis_tvalid : vmode;
   end

   // Output monitor: each beat must carry the previous cycle's valid input.
   always @(negedge aclk) begin
      if (m_axis_tvalid) begin
         beats = beats + 1;
         if (m_axis_tready) acc = acc + 1;
         if (!pv || m_axis_tdata != pd) dmis = dmis + 1;
         if (m_axis_tlast && tl_n < 256) begin
            tl_pos[tl_n] = beats;
            tl_n = tl_n + 1;
         end
      end else if (m_axis_tlast) begin
         dmis = dmis + 1;
      end
      pv = s_axis_tvalid;
      pd = s_axis_tdata;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic fire();
      trigger = 1'b1;
      cyc(2);
      trigger = 1'b0;
   endtask

   task automatic wait_up(output int low);
      low = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         if (fifo_rst_n) return;
         if (busy) low++;
      end
      chk("arm_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_beat();
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         if (m_axis_tvalid) return;
      end
      chk("beat_timeout", 32'd0, 32'd1);
   endtask

   task automatic arm_run(input logic [7:0] np, input logic [15:0] ns, st, en, output int low);
      enable = 1'b0;
      cyc(3);
      cfg_n_pulses = np; cfg_n_samples = ns; cfg_start_index = st; cfg_end_index = en;
      enable = 1'b1;
      wait_up(low);
   endtask

   initial begin
      #100us;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int low, b0, a0, t0;
      cyc(4);
      chk("rst_busy", busy, 0);
      chk("rst_fifo", fifo_rst_n, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_frame", frame_count, 0);
      chk("rst_flags", {cfg_err, trig_miss, overrun}, 0);
      chk("s_tready", s_axis_tready, 1);
      aresetn = 1'b1;
      cyc(2);

      // 1: happy path, 3 pulses x 8 samples
      b0 = beats; a0 = acc; t0 = tl_n;
      arm_run(8'd3, 16'd8, 16'd2, 16'd5, low);
      chk("arm_low_cycles", low, 16);
      chk("lat_cfg", {n_pulses, n_samples[7:0], start_index[7:0], end_index[7:0]}, 32'h03080205);
      for (int p = 0; p < 3; p++) begin
         fire();
         cyc(18);
      end
      chk("hp_beats", beats - b0, 24);
      chk("hp_acc", acc - a0, 24);
      chk("hp_tlast_n", tl_n - t0, 3);
      chk("hp_tlast0", tl_pos[t0] - b0, 8);
      chk("hp_tlast1", tl_pos[t0+1] - b0, 16);
      chk("hp_tlast2", tl_pos[t0+2] - b0, 24);
      chk("hp_frame", frame_count, 1);
      chk("hp_busy", busy, 1);

      // 2: bad config (start > end)
      enable = 1'b0;
      cyc(3);
      chk("stop_idle", busy, 0);
      b0 = beats;
      cfg_n_pulses = 8'd3; cfg_n_samples = 16'd8; cfg_start_index = 16'd6; cfg_end_index = 16'd5;
      enable = 1'b1;
      cyc(6);
      chk("bad_cfg_err", cfg_err, 1);
      chk("bad_busy", busy, 0);
      chk("bad_fifo", fifo_rst_n, 0);
      chk("bad_start_lat", start_index, 6);
      fire();
      cyc(10);
      chk("bad_no_out", beats - b0, 0);

      // 3: trigger during capture
      b0 = beats; t0 = tl_n;
      arm_run(8'd1, 16'd8, 16'd0, 16'd7, low);
      chk("good_cfg_err", cfg_err, 0);
      fire();
      wait_beat();
      fire();
      cyc(20);
      chk("miss_flag", trig_miss, 1);
      chk("miss_beats", beats - b0, 8);
      chk("miss_tlast_n", tl_n - t0, 1);
      chk("miss_wait", {busy, fifo_rst_n}, 2'b11);
      chk("miss_frame", frame_count, 2);

      // 4: gapped input
      arm_run(8'd1, 16'd4, 16'd0, 16'd3, low);
      chk("rearm_miss_clr", trig_miss, 0);
      b0 = beats; t0 = tl_n;
      gap = 1'b1;
      fire();
      cyc(30);
      gap = 1'b0;
      chk("gap_beats", beats - b0, 4);
      chk("gap_tlast_n", tl_n - t0, 1);
      chk("gap_tlast_pos", tl_pos[t0] - b0, 4);
      chk("gap_frame", frame_count, 3);

      // 5: downstream stall for 2 cycles mid-pulse
      b0 = beats; a0 = acc; t0 = tl_n;
      fire();
      wait_beat();
      cyc(1);
      m_axis_tready = 1'b0;
      cyc(2);
      m_axis_tready = 1'b1;
      cyc(15);
      chk("ovr_flag", overrun, 1);
      chk("ovr_beats", beats - b0, 4);
      chk("ovr_acc", acc - a0, 2);
      chk("ovr_tlast_pos", tl_pos[t0] - b0, 4);
      chk("ovr_frame", frame_count, 4);

      // 6: drop enable at pulse 2 of 3, then reset mid-capture
      arm_run(8'd3, 16'd4, 16'd0, 16'd3, low);
      chk("rearm_ovr_clr", overrun, 0);
      b0 = beats; t0 = tl_n;
      fire();
      cyc(18);
      fire();
      enable = 1'b0;
      cyc(18);
      chk("stop_mid_busy", busy, 1);
      fire();
      cyc(18);
      chk("stop_beats", beats - b0, 12);
      chk("stop_tlast_n", tl_n - t0, 3);
      chk("stop_frame", frame_count, 5);
      chk("stop_idle2", {busy, fifo_rst_n}, 2'b00);

      enable = 1'b1;
      wait_up(low);
      fire();
      wait_beat();
      aresetn = 1'b0;
      cyc(1);
      chk("mrst_out", {m_axis_tvalid, m_axis_tlast, busy, fifo_rst_n}, 0);
      chk("mrst_data", m_axis_tdata, 0);
      chk("mrst_frame", frame_count, 0);
      chk("mrst_cfg", {n_pulses, n_samples}, 0);
      enable = 1'b0;
      b0 = beats;
      cyc(3);
      aresetn = 1'b1;
      cyc(10);
      chk("mrst_no_out", beats - b0, 0);
      chk("data_path", dmis, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pulse_int_seq.md
Name: pulse_int_seq

Overview:
Sequencer placed upstream of the pulse integrator. It aligns the free-running ADC AXIS stream to an external pulse trigger and forwards exactly n_samples samples per trigger. It latches and validates the integrator configuration once per run and holds the integrator's FIFO in reset while arming. It also counts completed integration frames and raises sticky error flags for missed triggers and downstream overrun.

Parameters:
AXIS_DATA_WIDTH, 32, sample width
FIFO_RST_CYCLES, 16, cycles fifo_rst_n is held low when arming (must be >= 1)

Ports:
aclk  in  1  clock
aresetn  in  1  reset
enable  in  1  run request (level)
trigger  in  1  asynchronous pulse trigger
cfg_n_pulses  in  8  pulses per frame
cfg_n_samples  in  16  samples per pulse
cfg_start_index  in  16  first output sample
cfg_end_index  in  16  last output sample
s_axis_tdata  in  AXIS_DATA_WIDTH  ADC sample
s_axis_tvalid  in  1  ADC valid
s_axis_tready  out  1  constant 1; the ADC cannot stall
m_axis_tdata  out  AXIS_DATA_WIDTH  sample to integrator
m_axis_tvalid  out  1  valid to integrator
m_axis_tlast  out  1  last sample of pulse
m_axis_tready  in  1  integrator ready
fifo_rst_n  out  1  integrator FIFO reset, active-low
n_pulses, n_samples, start_index, end_index  out  8/16/16/16  latched config to integrator
busy  out  1  state != IDLE
cfg_err  out  1  last arm attempt rejected
trig_miss  out  1  sticky: trigger arrived during CAPTURE
overrun  out  1  sticky: m_axis_tvalid while m_axis_tready=0
frame_count  out  32  completed frames, wraps at 2^32

Behaviour:
- Reset is synchronous on aresetn low. Reset values: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fifo_rst_n=0, latched cfg=0, busy=0, all flags=0, frame_count=0, counters=0. Reset mid-operation aborts immediately; no partial-frame output follows.
- Trigger path: 2-flop synchronizer, then rising-edge detector. Effective latency is 3 cycles from the trigger edge to trig_rise.
- IDLE: fifo_rst_n=0, no output. On an enable rising edge, latch cfg_* into the output regs and validate.
  - Valid means n_pulses>=1, n_samples>=1, start_index<=end_index<n_samples.
  - Invalid: cfg_err=1, stay IDLE.
  - Valid: cfg_err=0, go to ARM.
- ARM: hold fifo_rst_n=0 for FIFO_RST_CYCLES cycles, then set fifo_rst_n=1 and go to WAIT_TRIG. sample_cnt=0, pulse_cnt=0.
- WAIT_TRIG: input samples are discarded. On trig_rise go to CAPTURE with sample_cnt=0.
  - If enable=0 and pulse_cnt==0 (frame boundary), go to IDLE instead.
  - trig_rise and enable-low in the same cycle: IDLE wins only at the frame boundary.
- CAPTURE: output is registered with 1-cycle latency. Each input beat with s_axis_tvalid=1 produces, next cycle:
  - m_axis_tvalid=1 and m_axis_tdata=s_axis_tdata;
  - m_axis_tlast=1 iff sample_cnt==n_samples-1;
  - sample_cnt increments.
- On the last beat of a pulse: sample_cnt=0, go to WAIT_TRIG.
  - If pulse_cnt==n_pulses-1: pulse_cnt=0 and frame_count+1.
  - Otherwise pulse_cnt+1.
- In CAPTURE, trig_rise is ignored and sets trig_miss.
- enable falling mid-frame: the current frame completes, then IDLE. Config inputs are ignored until the next IDLE→ARM.
- Overrun: any cycle with m_axis_tvalid=1 and m_axis_tready=0 sets overrun. The beat is dropped, not retried.
- Sticky flags clear only on reset or on a successful arm.
- Counters: sample_cnt is 16 bit and pulse_cnt is 8 bit. All compares are unsigned. cfg_n_samples=65535 is legal.

Decomposition:
- Package pulse_int_pkg holds:
  - the state enum (IDLE, ARM, WAIT_TRIG, CAPTURE);
  - width constants PULSE_W=8, SAMPLE_W=16, FRAME_W=32;
  - a cfg-valid function.
- One sub-module, sync_rise: a 2-flop synchronizer plus rising-edge pulse. Reused for trigger; not used for enable, which is already synchronous.

Test Plan:
1. Happy path. cfg n_pulses=3, n_samples=8, start=2, end=5; enable=1; 3 triggers spaced 20 cycles, continuous valid.
   - fifo_rst_n low for 16 cycles after arm.
   - 3×8 beats, tlast on beats 8/16/24.
   - frame_count=1.
2. Bad config. start=6, end=5 with enable rise → cfg_err=1, busy=0, no output, fifo_rst_n stays 0.
3. Missed trigger. Second trigger 4 cycles into CAPTURE with n_samples=8 → trig_miss=1, still exactly 8 beats, state returns to WAIT_TRIG.
4. Gapped input. s_axis_tvalid toggling 1/0, n_samples=4 → exactly 4 output beats, tlast on the 4th valid beat, no beats generated during gaps.
5. Downstream stall. m_axis_tready=0 for 2 cycles mid-pulse → overrun=1; the 2 beats are lost; sample_cnt still advances and tlast timing is unchanged.
6. Stop and reset. enable dropped at pulse 2 of 3 → the frame finishes, frame_count increments, then IDLE with fifo_rst_n=0. aresetn asserted mid-CAPTURE → all outputs at reset values the next cycle.
